decode_issue_ctrl: RTL and testbench

- In-order issue controller for the decode stage; buffers fetched 32-bit instructions and issues them to execute.
- Splits each instruction into RISC-V base-format fields: opcode, rd, func3, rs1, rs2, func7.
- Holds the head instruction until its source and destination registers are free in a 31-entry busy-bit scoreboard.
- Writeback clears busy bits; flush clears the queue, the output register and the scoreboard.

---
 rtl/decode_issue_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// In-order decode/issue controller: instruction FIFO, RISC-V field split,
// busy-bit scoreboard with RAW/WAW hold, and a saturating hazard-stall counter.
module decode_issue_ctrl #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_func3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_func7,
    output logic             out_illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned QCNT_W = PTR_W + 1;
    localparam logic [QCNT_W-1:0] FULL_CNT = QCNT_W'(QDEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]       r_mem [QDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [QCNT_W-1:0] r_count;
    logic              r_in_ready;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [6:0]        r_out_opcode;
    logic [4:0]        r_out_rd;
    logic [2:0]        r_out_func3;
    logic [4:0]        r_out_rs1;
    logic [4:0]        r_out_rs2;
    logic [6:0]        r_out_func7;
    logic              r_out_illegal;

    logic [31:0]       r_busy;
    logic [CNT_W-1:0]  r_stall;

    logic [31:0]       w_head;
    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_writes_rd;
    logic              w_illegal;
    logic [31:0]       w_wb_clr;
    logic [31:0]       w_eff;
    logic [31:0]       w_issue_set;
    logic [31:0]       w_busy_next;
    logic              w_not_empty;
    logic              w_hazard;
    logic              w_push;
    logic              w_load;
    logic [QCNT_W-1:0] w_count_next;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_opcode = w_head[6:0];
    assign w_rd     = w_head[11:7];
    assign w_rs1    = w_head[19:15];
    assign w_rs2    = w_head[24:20];

    // Operand usage per opcode class of the queue head
    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_writes_rd = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                w_use_rs1   = 1'b1;
                w_writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                w_writes_rd = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Writeback is folded in before the hazard check so it unblocks the head at once
    assign w_wb_clr    = wb_valid ? (32'(1) << wb_rd) : '0;
    assign w_eff       = r_busy & ~w_wb_clr;
    assign w_hazard    = (w_use_rs1 && w_eff[w_rs1]) ||
                         (w_use_rs2 && w_eff[w_rs2]) ||
                         (w_writes_rd && w_eff[w_rd]);
    assign w_not_empty = (r_count != '0);
    assign w_push      = in_valid && r_in_ready;
    assign w_load      = w_not_empty && !w_hazard && (!r_out_valid || out_ready);
    assign w_issue_set = (w_load && w_writes_rd && (w_rd != 5'd0)) ? (32'(1) << w_rd) : '0;
    assign w_busy_next = ((r_busy & ~w_wb_clr) | w_issue_set) & ~32'd1;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_load})
            2'b10:   w_count_next = r_count + QCNT_W'(1);
            2'b01:   w_count_next = r_count - QCNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Queue storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != FULL_CNT);
        end
    end

    // Issue register: load on issue, drop valid on accept, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_opcode  <= '0;
            r_out_rd      <= '0;
            r_out_func3   <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_func7   <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_instr   <= w_head;
            r_out_opcode  <= w_opcode;
            r_out_rd      <= w_writes_rd ? w_rd : 5'd0;
            r_out_func3   <= w_head[14:12];
            r_out_rs1     <= w_rs1;
            r_out_rs2     <= w_rs2;
            r_out_func7   <= w_head[31:25];
            r_out_illegal <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Stall history survives flush; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (!flush && w_not_empty && w_hazard && (r_stall != '1)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_opcode  = r_out_opcode;
    assign out_rd      = r_out_rd;
    assign out_func3   = r_out_func3;
    assign out_rs1     = r_out_rs1;
    assign out_rs2     = r_out_rs2;
    assign out_func7   = r_out_func7;
    assign out_illegal = r_out_illegal;
    assign busy        = r_busy;
    assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: decode table plus hand-written
// sequences for back-pressure, hazards, flush, set-wins and mid-run reset.
module tb_decode_issue_ctrl;

    localparam int unsigned QDEPTH = 4;
    localparam int unsigned CNT_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [6:0]       out_opcode;
    logic [4:0]       out_rd;
    logic [2:0]       out_func3;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [6:0]       out_func7;
    logic             out_illegal;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             flush;
    logic [31:0]      busy;
    logic [CNT_W-1:0] stall_cnt;

    decode_issue_ctrl #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func7(out_func7),
        .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic        ill;
        logic [31:0] busy;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] SUB = 32'h40118233;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_x(input int n);
        return 32'h00100013 | (32'(n) << 7);
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;

        vecs[0] = '{32'h002081B3, 7'h33, 5'd3, 3'd0, 5'd1,  5'd2,  7'h00, 1'b0, 32'h0000_0008};
        vecs[1] = '{32'h40118233, 7'h33, 5'd4, 3'd0, 5'd3,  5'd1,  7'h20, 1'b0, 32'h0000_0010};
        vecs[2] = '{32'h00100293, 7'h13, 5'd5, 3'd0, 5'd0,  5'd1,  7'h00, 1'b0, 32'h0000_0020};
        vecs[3] = '{32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0,  5'd0,  7'h00, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h0020A223, 7'h23, 5'd0, 3'd2, 5'd1,  5'd2,  7'h00, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h123453B7, 7'h37, 5'd7, 3'd5, 5'd8,  5'd3,  7'h09, 1'b0, 32'h0000_0080};
        vecs[6] = '{32'h00208463, 7'h63, 5'd0, 3'd0, 5'd1,  5'd2,  7'h00, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h008000EF, 7'h6F, 5'd1, 3'd0, 5'd0,  5'd8,  7'h00, 1'b0, 32'h0000_0002};
        vecs[8] = '{32'hFFFFFFFF, 7'h7F, 5'd0, 3'd7, 5'd31, 5'd31, 7'h7F, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'h00000013, 7'h13, 5'd0, 3'd0, 5'd0,  5'd0,  7'h00, 1'b0, 32'h0000_0000};

        // Reset state
        step(); step();
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_instr", out_instr,        32'd0);
        check("rst_out_rd",    32'(out_rd),      32'd0);
        check("rst_illegal",   32'(out_illegal), 32'd0);
        check("rst_busy",      busy,             32'd0);
        check("rst_stall",     32'(stall_cnt),   32'd0);
        rst_n = 1'b1;

        // Back-pressure: 1 in issue register + QDEPTH queued, then full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            in_instr = addi_x(n);
            step();
            check($sformatf("bp_in_ready_%0d", n), 32'(in_ready), (n < 5) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_instr", out_instr,      addi_x(1));
        check("bp_out_rd",    32'(out_rd),    32'd1);
        check("bp_busy",      busy,           32'h0000_0002);
        step(); step();
        check("bp_hold_instr", out_instr,      addi_x(1));
        check("bp_hold_rd",    32'(out_rd),    32'd1);
        check("bp_stall",      32'(stall_cnt), 32'd0);
        check("bp_full",       32'(in_ready),  32'd0);

        // Pop while full must not let a push in
        in_valid = 1'b1; in_instr = addi_x(6); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("drain_instr_2", out_instr,     addi_x(2));
        check("drain_ready",   32'(in_ready), 32'd1);
        for (int n = 3; n <= 5; n++) begin
            step();
            check($sformatf("drain_instr_%0d", n), out_instr, addi_x(n));
        end
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_busy",  busy,           32'h0000_003E);
        check("drain_stall", 32'(stall_cnt), 32'd0);

        // Flush with busy=0x18 and three queued
        flush = 1'b1; step(); flush = 1'b0;
        check("pre_flush_busy", busy, 32'd0);
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = addi_x(3); step();
        in_instr = addi_x(4); step();
        in_instr = addi_x(6); step();
        out_ready = 1'b0;
        in_instr = addi_x(7); step();
        in_instr = addi_x(8); step();
        in_valid = 1'b0;
        check("fl_setup_busy",  busy,           32'h0000_0018);
        check("fl_setup_instr", out_instr,      addi_x(4));
        check("fl_setup_ready", 32'(in_ready),  32'd1);
        flush = 1'b1; in_valid = 1'b1; in_instr = addi_x(9); out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_busy",      busy,           32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_stall",     32'(stall_cnt), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3;
        step();
        wb_valid = 1'b0;
        check("fl_wb_busy",   busy,           32'd0);
        check("fl_no_issue",  32'(out_valid), 32'd0);
        step();
        check("fl_no_issue2", 32'(out_valid), 32'd0);

        // Set wins over same-cycle clear of the same register
        in_valid = 1'b1; in_instr = 32'h00100293;
        step(); step();
        in_valid = 1'b0;
        check("sw_first_busy", busy, 32'h0000_0020);
        wb_valid = 1'b1; wb_rd = 5'd5;
        step();
        wb_valid = 1'b0;
        check("sw_valid", 32'(out_valid), 32'd1);
        check("sw_instr", out_instr,      32'h00100293);
        check("sw_busy",  busy,           32'h0000_0020);
        check("sw_stall", 32'(stall_cnt), 32'd0);
        step();
        check("sw_drained", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_instr = 32'h0;
        step();
        in_valid = 1'b0;
        step();
        check("ill_valid", 32'(out_valid),   32'd1);
        check("ill_flag",  32'(out_illegal), 32'd1);
        check("ill_rd",    32'(out_rd),      32'd0);
        check("ill_busy",  busy,             32'h0000_0020);

        // add then dependent sub: RAW stall until writeback of x3
        flush = 1'b1; step(); flush = 1'b0;
        in_valid = 1'b1; in_instr = ADD;
        step();
        check("lat_not_yet", 32'(out_valid), 32'd0);
        in_instr = SUB;
        step();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_instr", out_instr,      ADD);
        check("add_rd",    32'(out_rd),    32'd3);
        check("add_rs1",   32'(out_rs1),   32'd1);
        check("add_rs2",   32'(out_rs2),   32'd2);
        check("add_f7",    32'(out_func7), 32'd0);
        check("add_busy",  busy,           32'h0000_0008);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("raw_stall_%0d", k), 32'(stall_cnt), 32'(k));
            check($sformatf("raw_held_%0d", k),  32'(out_valid), 32'd0);
        end
        wb_valid = 1'b1; wb_rd = 5'd3;
        step();
        wb_valid = 1'b0;
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_instr", out_instr,      SUB);
        check("sub_f7",    32'(out_func7), 32'h20);
        check("sub_rd",    32'(out_rd),    32'd4);
        check("sub_busy",  busy,           32'h0000_0010);
        check("sub_stall", 32'(stall_cnt), 32'd3);

        // Decode table: one isolated issue per vector
        for (int i = 0; i < NVEC; i++) begin
            flush = 1'b1; step(); flush = 1'b0;
            in_valid = 1'b1; in_instr = vecs[i].instr;
            step();
            in_valid = 1'b0;
            step();
            check($sformatf("v%0d_valid", i), 32'(out_valid),   32'd1);
            check($sformatf("v%0d_instr", i), out_instr,        vecs[i].instr);
            check($sformatf("v%0d_op", i),    32'(out_opcode),  32'(vecs[i].op));
            check($sformatf("v%0d_rd", i),    32'(out_rd),      32'(vecs[i].rd));
            check($sformatf("v%0d_f3", i),    32'(out_func3),   32'(vecs[i].f3));
            check($sformatf("v%0d_rs1", i),   32'(out_rs1),     32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i),   32'(out_rs2),     32'(vecs[i].rs2));
            check($sformatf("v%0d_f7", i),    32'(out_func7),   32'(vecs[i].f7));
            check($sformatf("v%0d_ill", i),   32'(out_illegal), 32'(vecs[i].ill));
            check($sformatf("v%0d_busy", i),  busy,             vecs[i].busy);
        end
        check("tbl_stall_kept", 32'(stall_cnt), 32'd3);

        // Mid-operation reset with queued work and busy bits
        out_ready = 1'b0; flush = 1'b1; step(); flush = 1'b0;
        in_valid = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            in_instr = addi_x(n);
            step();
        end
        in_valid = 1'b0;
        step();
        check("mid_pre_busy",  busy,           32'h0000_0002);
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_in_ready",  32'(in_ready),    32'd1);
        check("mid_out_valid", 32'(out_valid),   32'd0);
        check("mid_out_instr", out_instr,        32'd0);
        check("mid_out_rd",    32'(out_rd),      32'd0);
        check("mid_out_rs1",   32'(out_rs1),     32'd0);
        check("mid_busy",      busy,             32'd0);
        check("mid_stall",     32'(stall_cnt),   32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        step(); step();
        check("mid_queue_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
